// File: rtl/reader_cmd_sched.sv
// Reader command scheduler: sequences Query -> ACK -> ReqRN -> Authenticate through the PIE
// encoder / backscatter decoder with response windows, retries and RN16 capture. Optional: CRYPTO_STEP_EN.
module reader_cmd_sched #(
    parameter int T_RESP_CYCLES   = 1024,
    parameter int T_CRYPTO_CYCLES = 65535,
    parameter int MAX_RETRY       = 3,
    parameter int CNT_W           = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [1:0]  testcase,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [3:0]  cmd_code,
    output logic [15:0] cmd_arg,
    input  logic        tx_done,
    input  logic        rx_valid,
    input  logic        rx_crc_ok,
    input  logic [15:0] rx_data,
    output logic        busy,
    output logic        done,
    output logic [1:0]  status,
    output logic [15:0] rn16,
    output logic [1:0]  retry_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_SEND, S_WAIT_TX, S_LISTEN, S_NEXT, S_ABORT, S_DONE
    } state_t;

    localparam logic [1:0]       ST_OK        = 2'b00;
    localparam logic [1:0]       ST_TIMEOUT   = 2'b01;
    localparam logic [1:0]       ST_CRC       = 2'b10;
    localparam logic [1:0]       ST_ABORTED   = 2'b11;
    localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRY);
    localparam logic [CNT_W-1:0] RESP_LIMIT   = CNT_W'(T_RESP_CYCLES);
    localparam logic [CNT_W-1:0] CRYPTO_LIMIT = CNT_W'(T_CRYPTO_CYCLES);

    // Final step index of a round for each testcase; testcase 3 loops back after it.
    function automatic logic [1:0] last_step(input logic [1:0] tc);
`ifdef CRYPTO_STEP_EN
        return (tc == 2'd0) ? 2'd1 : (tc == 2'd1) ? 2'd2 : 2'd3;
`else
        return (tc == 2'd0) ? 2'd1 : 2'd2;
`endif
    endfunction

    state_t           state_q, state_d;
    logic [1:0]       step_q, step_d, tc_q, tc_d, retry_q, retry_d, status_q, status_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      rn16_q, rn16_d, cmd_arg_q, cmd_arg_d;
    logic [3:0]       cmd_code_q, cmd_code_d;
    logic             cmd_valid_q, cmd_valid_d, busy_q, busy_d, done_q, done_d;

    logic [CNT_W-1:0] limit, cnt_inc;
    logic [1:0]       retry_inc, next_step, fail_code;
    logic             fail;

    always_comb begin
        // NOTE: every _d takes its hold value first so no path through the case can infer a latch.
        state_d     = state_q;
        step_d      = step_q;
        tc_d        = tc_q;
        cnt_d       = cnt_q;
        retry_d     = retry_q;
        rn16_d      = rn16_q;
        cmd_valid_d = cmd_valid_q;
        cmd_code_d  = cmd_code_q;
        cmd_arg_d   = cmd_arg_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        status_d    = status_q;
        fail        = 1'b0;
        fail_code   = ST_CRC;
        limit       = (step_q == 2'd3) ? CRYPTO_LIMIT : RESP_LIMIT;
        cnt_inc     = cnt_q + CNT_W'(1);
        retry_inc   = retry_q + 2'd1;
        next_step   = step_q + 2'd1;

        case (state_q)
            S_IDLE: if (start) begin
                tc_d        = testcase;
                retry_d     = 2'd0;
                step_d      = 2'd0;
                busy_d      = 1'b1;
                status_d    = ST_OK;
                cmd_valid_d = 1'b1;
                cmd_code_d  = 4'd1;
                cmd_arg_d   = 16'h0000;
                state_d     = S_SEND;
            end
            S_SEND: if (cmd_valid_q && cmd_ready) begin
                cmd_valid_d = 1'b0;
                state_d     = S_WAIT_TX;
            end
            S_WAIT_TX: if (tx_done) begin
                cnt_d   = '0;
                state_d = S_LISTEN;
            end
            S_LISTEN: begin
                if (cnt_q != limit) cnt_d = cnt_inc;
                // A reply landing on the last window cycle wins over the timeout.
                if (rx_valid && rx_crc_ok) begin
                    if (step_q == 2'd0) rn16_d = rx_data;
                    state_d = S_NEXT;
                end else if (rx_valid) begin
                    fail = 1'b1;
                end else if (cnt_inc == limit) begin
                    fail      = 1'b1;
                    fail_code = ST_TIMEOUT;
                end
                if (fail) begin
                    retry_d = retry_inc;
                    if (retry_inc == RETRY_LIMIT) begin
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        status_d = fail_code;
                        state_d  = S_DONE;
                    end else begin
                        step_d      = 2'd0;
                        cmd_valid_d = 1'b1;
                        cmd_code_d  = 4'd1;
                        cmd_arg_d   = 16'h0000;
                        state_d     = S_SEND;
                    end
                end
            end
            S_NEXT: begin
                if (step_q != last_step(tc_q)) begin
                    step_d      = next_step;
                    cmd_valid_d = 1'b1;
                    cmd_code_d  = {2'b00, next_step} + 4'd1;
                    cmd_arg_d   = rn16_q;
                    state_d     = S_SEND;
                end else if (tc_q == 2'd3) begin
                    step_d      = 2'd0;
                    retry_d     = 2'd0;
                    cmd_valid_d = 1'b1;
                    cmd_code_d  = 4'd1;
                    cmd_arg_d   = 16'h0000;
                    state_d     = S_SEND;
                end else begin
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    status_d = ST_OK;
                    state_d  = S_DONE;
                end
            end
            S_ABORT: begin
                done_d   = 1'b1;
                busy_d   = 1'b0;
                status_d = ST_ABORTED;
                state_d  = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Abort drops the request first and reports through the normal DONE pulse a cycle later.
        if (abort && (state_q inside {S_SEND, S_WAIT_TX, S_LISTEN, S_NEXT})) begin
            cmd_valid_d = 1'b0;
            done_d      = 1'b0;
            busy_d      = 1'b1;
            status_d    = status_q;
            state_d     = S_ABORT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            step_q      <= 2'd0;
            tc_q        <= 2'd0;
            cnt_q       <= '0;
            retry_q     <= 2'd0;
            rn16_q      <= 16'h0000;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= 4'd0;
            cmd_arg_q   <= 16'h0000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            status_q    <= 2'b00;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            tc_q        <= tc_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            rn16_q      <= rn16_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            cmd_arg_q   <= cmd_arg_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            status_q    <= status_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_code  = cmd_code_q;
    assign cmd_arg   = cmd_arg_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign status    = status_q;
    assign rn16      = rn16_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_reader_cmd_sched.sv
// Self-checking bench for reader_cmd_sched: table of command exchanges with a command scoreboard,
// plus hand sequences for reset behaviour. Define CRYPTO_STEP_EN to exercise the Authenticate step.
module tb_reader_cmd_sched;

    localparam int T_RESP   = 1024;
    localparam int T_CRYPTO = 65535;
    localparam int R_NONE   = 0;
    localparam int R_OK     = 1;
    localparam int R_BAD    = 2;
    localparam int R_ABORT  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  testcase = 2'd0;
    logic        cmd_ready = 1'b0;
    logic        tx_done = 1'b0;
    logic        rx_valid = 1'b0;
    logic        rx_crc_ok = 1'b0;
    logic [15:0] rx_data = 16'h0000;
    logic        cmd_valid, busy, done;
    logic [3:0]  cmd_code;
    logic [15:0] cmd_arg, rn16;
    logic [1:0]  status, retry_cnt;

    reader_cmd_sched #(
        .T_RESP_CYCLES(T_RESP), .T_CRYPTO_CYCLES(T_CRYPTO), .MAX_RETRY(3), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .testcase(testcase),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_code(cmd_code), .cmd_arg(cmd_arg),
        .tx_done(tx_done), .rx_valid(rx_valid), .rx_crc_ok(rx_crc_ok), .rx_data(rx_data),
        .busy(busy), .done(done), .status(status), .rn16(rn16), .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    // One command exchange; 'first' starts a round, 'last' closes it with the expected results.
    typedef struct {
        bit          first;
        logic [1:0]  tc;
        logic [3:0]  code;
        logic [15:0] arg;
        int          ready_dly;
        int          reply;
        int          reply_dly;
        logic [15:0] data;
        bit          last;
        int          done_lat;
        logic [1:0]  st;
        logic [1:0]  rc;
        logic [15:0] rn;
    } vec_t;

    vec_t        vecs[$];
    logic [19:0] exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input bit first, input logic [1:0] tc, input logic [3:0] code,
                       input logic [15:0] arg, input int rdy, input int reply, input int dly,
                       input logic [15:0] data, input bit last, input int lat,
                       input logic [1:0] st, input logic [1:0] rc, input logic [15:0] rn);
        vec_t v;
        v.first = first; v.tc = tc; v.code = code; v.arg = arg; v.ready_dly = rdy;
        v.reply = reply; v.reply_dly = dly; v.data = data; v.last = last;
        v.done_lat = lat; v.st = st; v.rc = rc; v.rn = rn;
        vecs.push_back(v);
    endtask

    // Scoreboard: every accepted command must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && cmd_valid && cmd_ready) begin
            check("sb_pending", 32'(exp_q.size()), 32'd1);
            if (exp_q.size() > 0) check("cmd_word", 32'({cmd_code, cmd_arg}), 32'(exp_q.pop_front()));
        end
    end

    task automatic run_vec(input vec_t v);
        int k;
        if (v.first) begin
            testcase = v.tc;
            start = 1'b1;
            tick();
            start = 1'b0;
            check("start_to_cmd_valid", 32'(cmd_valid), 32'd1);
        end
        exp_q.push_back({v.code, v.arg});
        k = 0;
        while (!cmd_valid && k < 64) begin tick(); k++; end
        check("cmd_valid_seen", 32'(cmd_valid), 32'd1);
        check("cmd_code", 32'(cmd_code), 32'(v.code));
        for (int i = 0; i < v.ready_dly; i++) begin
            tick();
            check("stall_valid", 32'(cmd_valid), 32'd1);
            check("stall_code", 32'(cmd_code), 32'(v.code));
        end
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        check("cmd_valid_drop", 32'(cmd_valid), 32'd0);
        tick();
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        if (v.reply == R_NONE) begin
            k = 0;
            while (!cmd_valid && !done && k < T_CRYPTO + 8) begin tick(); k++; end
            check("timeout_window", 32'(k), 32'(T_RESP));
        end else begin
            repeat (v.reply_dly) tick();
            if (v.reply == R_ABORT) abort = 1'b1;
            else begin
                rx_valid  = 1'b1;
                rx_crc_ok = (v.reply == R_OK);
                rx_data   = v.data;
            end
            tick();
            abort = 1'b0; rx_valid = 1'b0; rx_crc_ok = 1'b0;
            if (!v.last && v.reply == R_OK) begin
                check("next_gap", 32'(cmd_valid | done), 32'd0);
                tick();
                check("reply_to_cmd", 32'(cmd_valid), 32'd1);
                check("no_done_mid_round", 32'(done), 32'd0);
            end
            if (v.last) begin
                k = 0;
                while (!done && k < 8) begin tick(); k++; end
                check("done_latency", 32'(k), 32'(v.done_lat));
            end
        end
        if (v.last) begin
            check("done", 32'(done), 32'd1);
            check("status", 32'(status), 32'(v.st));
            check("retry_cnt", 32'(retry_cnt), 32'(v.rc));
            check("rn16", 32'(rn16), 32'(v.rn));
            check("busy_at_done", 32'(busy), 32'd0);
            tick();
            check("done_one_cycle", 32'(done), 32'd0);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Normal round, testcase 0.
        add(1, 0, 4'd1, 16'h0000, 0, R_OK, 5, 16'hBEEF, 0, 0, 2'b00, 2'd0, 16'h0000);
        add(0, 0, 4'd2, 16'hBEEF, 0, R_OK, 3, 16'h1234, 1, 1, 2'b00, 2'd0, 16'hBEEF);
        // Stalled encoder, then a reply on the final window cycle.
        add(1, 1, 4'd1, 16'h0000, 10, R_OK, 0, 16'hA5A5, 0, 0, 2'b00, 2'd0, 16'h0000);
        add(0, 1, 4'd2, 16'hA5A5, 0, R_OK, 20, 16'h0000, 0, 0, 2'b00, 2'd0, 16'h0000);
        add(0, 1, 4'd3, 16'hA5A5, 2, R_OK, T_RESP - 1, 16'hFFFF, 1, 1, 2'b00, 2'd0, 16'hA5A5);
        // Three timeouts.
        add(1, 0, 4'd1, 16'h0000, 0, R_NONE, 0, 16'h0000, 0, 0, 2'b00, 2'd0, 16'h0000);
        add(0, 0, 4'd1, 16'h0000, 0, R_NONE, 0, 16'h0000, 0, 0, 2'b00, 2'd0, 16'h0000);
        add(0, 0, 4'd1, 16'h0000, 0, R_NONE, 0, 16'h0000, 1, 0, 2'b01, 2'd3, 16'hA5A5);
        // One CRC failure after ACK, then recovery from Query.
        add(1, 0, 4'd1, 16'h0000, 0, R_OK, 2, 16'hC0DE, 0, 0, 2'b00, 2'd0, 16'h0000);
        add(0, 0, 4'd2, 16'hC0DE, 0, R_BAD, 4, 16'h0000, 0, 0, 2'b00, 2'd0, 16'h0000);
        add(0, 0, 4'd1, 16'h0000, 0, R_OK, 6, 16'h7777, 0, 0, 2'b00, 2'd0, 16'h0000);
        add(0, 0, 4'd2, 16'h7777, 0, R_OK, 1, 16'h0000, 1, 1, 2'b00, 2'd1, 16'h7777);
        // CRC failures exhaust the retries.
        add(1, 1, 4'd1, 16'h0000, 0, R_BAD, 3, 16'h0000, 0, 0, 2'b00, 2'd0, 16'h0000);
        add(0, 1, 4'd1, 16'h0000, 0, R_BAD, 3, 16'h0000, 0, 0, 2'b00, 2'd0, 16'h0000);
        add(0, 1, 4'd1, 16'h0000, 0, R_BAD, 3, 16'h0000, 1, 0, 2'b10, 2'd3, 16'h7777);
        // Abort while listening.
        add(1, 1, 4'd1, 16'h0000, 0, R_ABORT, 10, 16'h0000, 1, 1, 2'b11, 2'd0, 16'h7777);
        // Testcase 2: Authenticate with a late reply, or ReqRN as the final step.
        add(1, 2, 4'd1, 16'h0000, 0, R_OK, 4, 16'h1357, 0, 0, 2'b00, 2'd0, 16'h0000);
        add(0, 2, 4'd2, 16'h1357, 0, R_OK, 4, 16'h0000, 0, 0, 2'b00, 2'd0, 16'h0000);
`ifdef CRYPTO_STEP_EN
        add(0, 2, 4'd3, 16'h1357, 0, R_OK, 4, 16'h0000, 0, 0, 2'b00, 2'd0, 16'h0000);
        add(0, 2, 4'd4, 16'h1357, 0, R_OK, 5000, 16'h0000, 1, 1, 2'b00, 2'd0, 16'h1357);
`else
        add(0, 2, 4'd3, 16'h1357, 0, R_OK, 4, 16'h0000, 1, 1, 2'b00, 2'd0, 16'h1357);
`endif
        // Continuous testcase 3: retry, full loop, retry count cleared, then abort.
        add(1, 3, 4'd1, 16'h0000, 0, R_BAD, 2, 16'h0000, 0, 0, 2'b00, 2'd0, 16'h0000);
        add(0, 3, 4'd1, 16'h0000, 0, R_OK, 2, 16'h2468, 0, 0, 2'b00, 2'd0, 16'h0000);
        add(0, 3, 4'd2, 16'h2468, 0, R_OK, 2, 16'h0000, 0, 0, 2'b00, 2'd0, 16'h0000);
        add(0, 3, 4'd3, 16'h2468, 0, R_OK, 2, 16'h0000, 0, 0, 2'b00, 2'd0, 16'h0000);
`ifdef CRYPTO_STEP_EN
        add(0, 3, 4'd4, 16'h2468, 0, R_OK, 7, 16'h0000, 0, 0, 2'b00, 2'd0, 16'h0000);
`endif
        add(0, 3, 4'd1, 16'h0000, 0, R_ABORT, 3, 16'h0000, 1, 1, 2'b11, 2'd0, 16'h2468);

        // Reset values.
        tick();
        tick();
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd_code", 32'(cmd_code), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_status", 32'(status), 32'd0);
        check("rst_rn16", 32'(rn16), 32'd0);
        check("rst_retry", 32'(retry_cnt), 32'd0);
        rst_n = 1'b1;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        check("idle_abort_done", 32'(done), 32'd0);
        check("idle_abort_busy", 32'(busy), 32'd0);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of SEND.
        testcase = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("send_before_reset", 32'(cmd_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("reset_drops_valid", 32'(cmd_valid), 32'd0);
        check("reset_clears_busy", 32'(busy), 32'd0);
        check("reset_clears_rn16", 32'(rn16), 32'd0);
        repeat (2) begin tick(); check("no_done_in_reset", 32'(done), 32'd0); end
        rst_n = 1'b1;
        repeat (3) begin
            tick();
            check("no_done_after_reset", 32'(done), 32'd0);
            check("idle_after_reset", 32'(busy | cmd_valid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reader_cmd_sched.md
Name: reader_cmd_sched

Overview:
- Reader-side command scheduler that sequences one tag-access round through the reader's PIE transmit encoder and backscatter receive decoder.
- Round order: Query -> ACK -> ReqRN -> Authenticate (crypto).
- Owns response-window timing, retry policy and RN16 handle capture.
- Sits between the reader test/control logic (testcase select, start) and the encoder/decoder datapath in the reader top level.

Parameters:
- T_RESP_CYCLES, 1024, response window in clk cycles for Query/ACK/ReqRN replies, counted from tx_done.
- T_CRYPTO_CYCLES, 65535, response window for the Authenticate reply.
- MAX_RETRY, 3, failed attempts allowed before the round aborts.
- CNT_W, 16, width of the window counter; must hold max(T_RESP_CYCLES, T_CRYPTO_CYCLES).

Ports:
- clk  in  1  scheduler clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins a round when idle.
- abort  in  1  level; forces the round to end.
- testcase  in  2  sequence select, sampled at start.
- cmd_valid  out  1  command request to the PIE encoder.
- cmd_ready  in  1  encoder accepts the command.
- cmd_code  out  4  1=Query, 2=ACK, 3=ReqRN, 4=Authenticate.
- cmd_arg  out  16  RN16 handle for ACK/ReqRN/Authenticate; 0 for Query.
- tx_done  in  1  pulse; encoder finished the last symbol.
- rx_valid  in  1  pulse; decoder has a complete reply.
- rx_crc_ok  in  1  qualifies rx_valid.
- rx_data  in  16  first 16 reply bits.
- busy  out  1  round in progress.
- done  out  1  one-cycle pulse at round end.
- status  out  2  00 ok, 01 timeout exhausted, 10 CRC exhausted, 11 aborted.
- rn16  out  16  last captured handle.
- retry_cnt  out  2  attempts failed in the current round.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; step index 0.
- States:
  - IDLE: start latches testcase, clears retry_cnt, sets step=0, busy=1, then goes to SEND. start while busy is ignored.
  - SEND: cmd_valid=1 with cmd_code/cmd_arg held stable. Handshake completes on cmd_valid&cmd_ready; cmd_valid drops the next cycle; go to WAIT_TX.
  - WAIT_TX: wait for tx_done. Clear the window counter, go to LISTEN.
  - LISTEN: counter increments every cycle.
    - rx_valid&rx_crc_ok: if step 0 (Query), rn16<=rx_data. Go to NEXT.
    - rx_valid&!rx_crc_ok: CRC failure.
    - Counter reaches the window limit (T_CRYPTO_CYCLES for step 3, else T_RESP_CYCLES) with no rx_valid: timeout.
    - rx_valid and limit in the same cycle: counts as a reply, not a timeout.
    - rx_valid outside LISTEN is ignored.
  - Failure path: retry_cnt+1. If the new value equals MAX_RETRY, go to DONE with status 01 (timeout) or 10 (CRC). Otherwise step=0 and go to SEND, so the retry restarts with Query.
  - NEXT: advance step. Last step per testcase:
    - 0: ACK.
    - 1: ReqRN.
    - 2: Authenticate.
    - 3: Authenticate, then on success return to step 0 and restart without asserting done (continuous); retry_cnt cleared each successful loop.
    - After the last step, go to DONE with status 00.
  - DONE: done=1 for one cycle, busy=0, status held until the next start. Go to IDLE.
- abort: sampled in every non-IDLE state. Next cycle: cmd_valid=0, then DONE with status 11. Abort in IDLE has no effect.
- Latency:
  - start to cmd_valid: 1 cycle.
  - reply accepted to next cmd_valid: 2 cycles (LISTEN->NEXT->SEND).
- Counter saturates at the limit; no wrap.
- Asynchronous reset mid-round: immediate return to reset values, no done pulse.

Optional Feature:
- CRYPTO_STEP_EN defined: Authenticate step (code 4, T_CRYPTO_CYCLES window) is present.
- Not defined: step 3 is removed. testcase 2 behaves as 1. testcase 3 loops Query/ACK/ReqRN. T_CRYPTO_CYCLES is unused.

Test Plan:
- Normal round: testcase=0, start; decoder replies 0xBEEF (crc ok) after Query, then any ok reply after ACK -> codes 1 then 2, ACK cmd_arg=0xBEEF, rn16=0xBEEF, done with status 00, retry_cnt 0.
- Stalled encoder: hold cmd_ready=0 for 10 cycles -> cmd_valid and code stay stable throughout; exactly one command is issued.
- Timeouts: no reply ever -> three Query attempts, each listening exactly T_RESP_CYCLES after tx_done; done with status 01, retry_cnt 3.
- One CRC failure: bad-CRC reply after ACK, then good replies -> Query reissued, retry_cnt 1, round completes with status 00.
- Crypto window (CRYPTO_STEP_EN, testcase=2): Authenticate reply at cycle 5000 after tx_done -> accepted, status 00. Rebuilt without the macro -> code 4 is never issued.
- Abort and reset: abort during LISTEN -> done next+1 cycle, status 11. rst_n low mid-SEND -> cmd_valid 0 immediately, no done.
